// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Package : rv32i_types
//  Shared RV32I pipeline types: writeback mux select, load/store width
//  encodings, memory-stage FSM states and the rvfi trace bundle.
//  Revision: 1.0
// ============================================================================
package rv32i_types;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // funct3[1:0] selects the access size for both loads and stores
  localparam logic [1:0] C_SIZE_BYTE = 2'b00;
  localparam logic [1:0] C_SIZE_HALF = 2'b01;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic        trap;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic        load_regfile;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_sigs;

endpackage
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
//  Module  : mem_align
//  Byte-lane alignment for the memory stage: byte masks, lane-shifted store
//  data, right-justified load data and the misalignment flag.
//  Revision: 1.0
// ============================================================================
module mem_align
  import rv32i_types::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [3:0]  rmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [3:0] mask;
  logic       mis;

  // Mask pattern by access size; a misaligned access enables no lanes
  always_comb begin
    mask = 4'b1111;
    mis  = |addr_lo_i;
    case (funct3_i[1:0])
      C_SIZE_BYTE: begin
        mask = 4'b0001 << addr_lo_i;
        mis  = 1'b0;
      end
      C_SIZE_HALF: begin
        mask = 4'b0011 << addr_lo_i;
        mis  = addr_lo_i[0];
      end
      default: begin
        mask = 4'b1111;
        mis  = |addr_lo_i;
      end
    endcase
    if (mis) begin
      mask = 4'b0000;
    end
  end

  assign wmask_o      = mask;
  assign rmask_o      = mask;
  assign misaligned_o = mis;
  assign wdata_o      = rs2_i << {addr_lo_i, 3'b000};
  assign rdata_o      = rdata_i >> {addr_lo_i, 3'b000};

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_stage
//  Memory-access pipeline stage: issues data-memory requests, holds the
//  pipeline until the response, and registers the MEM/WB bundle.
//  Revision: 1.0
// ============================================================================
module mem_stage
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic [31:0]     ex_alu_out_i,
  input  logic [31:0]     ex_rs2_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic            ex_is_load_i,
  input  logic            ex_is_store_i,
  input  logic            ex_br_en_i,
  input  logic [31:0]     ex_imm_i,
  input  logic [31:0]     ex_pc_plus4_i,
  input  regfilemux_sel_t ex_regfilemux_sel_i,
  input  logic [4:0]      ex_rd_i,
  input  rvfi_sigs        ex_rvfi_i,
  output logic [31:0]     dmem_address,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [3:0]      dmem_wmask,
  output logic [31:0]     dmem_wdata,
  input  logic [31:0]     dmem_rdata,
  input  logic            dmem_resp,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic [31:0]     wb_mem_rdata_o,
  output logic [31:0]     wb_alu_out_o,
  output logic            wb_br_en_o,
  output logic [31:0]     wb_imm_o,
  output logic [31:0]     wb_pc_plus4_o,
  output regfilemux_sel_t wb_regfilemux_sel_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_misaligned_o,
  output rvfi_sigs        wb_rvfi_o
);

  logic [3:0]  wmask;
  logic [3:0]  rmask;
  logic [31:0] wdata;
  logic [31:0] rdata_aligned;
  logic        misaligned;
  logic        is_mem;
  logic        memop;
  logic        hold;
  logic        is_ld_op;
  logic        is_st_op;
  mem_state_t  state_q;
  rvfi_sigs    rvfi_d;

  mem_align u_align (
    .addr_lo_i    (ex_alu_out_i[1:0]),
    .funct3_i     (ex_funct3_i),
    .rs2_i        (ex_rs2_i),
    .rdata_i      (dmem_rdata),
    .wmask_o      (wmask),
    .rmask_o      (rmask),
    .wdata_o      (wdata),
    .rdata_o      (rdata_aligned),
    .misaligned_o (misaligned)
  );

  assign is_mem   = ex_is_load_i | ex_is_store_i;
  assign memop    = ex_valid_i & is_mem & ~misaligned;
  assign is_ld_op = memop & ex_is_load_i;
  assign is_st_op = memop & ex_is_store_i;
  // A response without an outstanding request never qualifies anything
  assign hold     = memop & ~dmem_resp;

  // Gating with rst_n drops the request the instant reset asserts
  assign dmem_read    = rst_n & is_ld_op;
  assign dmem_write   = rst_n & is_st_op;
  assign dmem_address = (rst_n & memop) ? {ex_alu_out_i[31:2], 2'b00} : 32'd0;
  assign dmem_wmask   = dmem_write ? wmask : 4'd0;
  assign dmem_wdata   = dmem_write ? wdata : 32'd0;
  assign stall_o      = rst_n & hold;

  // Access sequencing: wait in WAIT until the memory answers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (memop && !dmem_resp) state_q <= WAIT;
        WAIT:    if (dmem_resp)           state_q <= IDLE;
        default:                          state_q <= IDLE;
      endcase
    end
  end

  // Trace bundle with the memory-side fields filled in here
  always_comb begin
    rvfi_d           = ex_rvfi_i;
    rvfi_d.mem_addr  = ex_alu_out_i;
    rvfi_d.mem_rmask = is_ld_op ? rmask : 4'd0;
    rvfi_d.mem_wmask = is_st_op ? wmask : 4'd0;
    rvfi_d.mem_rdata = is_ld_op ? dmem_rdata : 32'd0;
    rvfi_d.mem_wdata = is_st_op ? wdata : 32'd0;
  end

  // MEM/WB register: capture when the stage advances, bubble while holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o          <= 1'b0;
      wb_mem_rdata_o      <= 32'd0;
      wb_alu_out_o        <= 32'd0;
      wb_br_en_o          <= 1'b0;
      wb_imm_o            <= 32'd0;
      wb_pc_plus4_o       <= 32'd0;
      wb_regfilemux_sel_o <= rf_alu_out;
      wb_rd_o             <= 5'd0;
      wb_misaligned_o     <= 1'b0;
      wb_rvfi_o           <= '0;
    end else begin
      wb_valid_o          <= ex_valid_i & ~hold;
      wb_mem_rdata_o      <= rdata_aligned;
      wb_alu_out_o        <= ex_alu_out_i;
      wb_br_en_o          <= ex_br_en_i;
      wb_imm_o            <= ex_imm_i;
      wb_pc_plus4_o       <= ex_pc_plus4_i;
      wb_regfilemux_sel_o <= ex_regfilemux_sel_i;
      wb_rd_o             <= hold ? 5'd0 : ex_rd_i;
      wb_misaligned_o     <= ex_valid_i & is_mem & misaligned;
      wb_rvfi_o           <= rvfi_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_stage
//  Self-checking bench for mem_stage with a responding memory and a
//  reference model of byte-lane behaviour.
//  Revision: 1.0
// ============================================================================
module tb_mem_stage;
  import rv32i_types::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid_i, ex_is_load_i, ex_is_store_i, ex_br_en_i;
  logic [31:0]     ex_alu_out_i, ex_rs2_i, ex_imm_i, ex_pc_plus4_i;
  logic [2:0]      ex_funct3_i;
  regfilemux_sel_t ex_regfilemux_sel_i;
  logic [4:0]      ex_rd_i;
  rvfi_sigs        ex_rvfi_i;
  logic [31:0]     dmem_address, dmem_wdata, dmem_rdata;
  logic            dmem_read, dmem_write, dmem_resp, stall_o;
  logic [3:0]      dmem_wmask;
  logic            wb_valid_o, wb_br_en_o, wb_misaligned_o;
  logic [31:0]     wb_mem_rdata_o, wb_alu_out_o, wb_imm_o, wb_pc_plus4_o;
  regfilemux_sel_t wb_regfilemux_sel_o;
  logic [4:0]      wb_rd_o;
  rvfi_sigs        wb_rvfi_o;

  int n_checks = 0;
  int n_fail   = 0;

  // observations gathered by the memory driver
  int          obs_cycles, obs_stall_cycles, obs_req_cycles, obs_bubbles;
  logic        obs_read0, obs_write0, obs_changed;
  logic [31:0] obs_addr0, obs_wdata0;
  logic [3:0]  obs_wmask0;
  logic        wb_hist[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_alu_out_i(ex_alu_out_i), .ex_rs2_i(ex_rs2_i),
    .ex_funct3_i(ex_funct3_i), .ex_is_load_i(ex_is_load_i), .ex_is_store_i(ex_is_store_i),
    .ex_br_en_i(ex_br_en_i), .ex_imm_i(ex_imm_i), .ex_pc_plus4_i(ex_pc_plus4_i),
    .ex_regfilemux_sel_i(ex_regfilemux_sel_i), .ex_rd_i(ex_rd_i), .ex_rvfi_i(ex_rvfi_i),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall_o(stall_o),
    .wb_valid_o(wb_valid_o), .wb_mem_rdata_o(wb_mem_rdata_o), .wb_alu_out_o(wb_alu_out_o),
    .wb_br_en_o(wb_br_en_o), .wb_imm_o(wb_imm_o), .wb_pc_plus4_o(wb_pc_plus4_o),
    .wb_regfilemux_sel_o(wb_regfilemux_sel_o), .wb_rd_o(wb_rd_o),
    .wb_misaligned_o(wb_misaligned_o), .wb_rvfi_o(wb_rvfi_o)
  );

  // Presents one EX/MEM slot (called just after a rising edge) and plays the
  // memory: resp rises once nwait cycles have elapsed, rdata is garbage
  // unless resp is high. Returns after the edge on which the slot retires.
  task automatic drive_op(input logic v, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input int nwait);
    int   c;
    logic done;
    ex_valid_i          = v;
    ex_is_load_i        = ld;
    ex_is_store_i       = st;
    ex_funct3_i         = f3;
    ex_alu_out_i        = addr;
    ex_rs2_i            = rs2;
    ex_imm_i            = $urandom;
    ex_pc_plus4_i       = $urandom;
    ex_br_en_i          = 1'($urandom);
    ex_rd_i             = 5'($urandom_range(1, 31));
    ex_regfilemux_sel_i = regfilemux_sel_t'(4'($urandom_range(0, 8)));
    ex_rvfi_i           = '0;
    ex_rvfi_i.valid     = v;
    ex_rvfi_i.order     = {$urandom, $urandom};
    ex_rvfi_i.inst      = $urandom;
    ex_rvfi_i.pc_rdata  = $urandom;
    ex_rvfi_i.rd_wdata  = $urandom;
    ex_rvfi_i.mem_addr  = $urandom;
    ex_rvfi_i.mem_rdata = $urandom;
    obs_stall_cycles = 0; obs_req_cycles = 0; obs_bubbles = 0; obs_changed = 1'b0;
    done = 1'b0;
    c    = 0;
    while (!done && c < 16) begin
      dmem_resp  = (c >= nwait);
      dmem_rdata = dmem_resp ? rdata : $urandom;
      @(negedge clk);
      if (stall_o) obs_stall_cycles++;
      if (dmem_read || dmem_write) obs_req_cycles++;
      if (c == 0) begin
        obs_read0 = dmem_read; obs_write0 = dmem_write; obs_addr0 = dmem_address;
        obs_wmask0 = dmem_wmask; obs_wdata0 = dmem_wdata;
      end else if (dmem_read !== obs_read0 || dmem_write !== obs_write0 ||
                   dmem_address !== obs_addr0 || dmem_wmask !== obs_wmask0 ||
                   dmem_wdata !== obs_wdata0) begin
        obs_changed = 1'b1;
      end
      done = (stall_o === 1'b0);
      @(posedge clk); #1;
      c++;
      wb_hist.push_back(wb_valid_o);
      if (!done && wb_valid_o === 1'b0 && wb_rd_o === 5'd0) obs_bubbles++;
    end
    obs_cycles = c;
    dmem_resp  = 1'b0;
    ex_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    n_checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got=%b%b want=00", dmem_read, dmem_write); end
    n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid_o); end
    n_checks++; if (wb_rd_o !== 5'd0 || wb_mem_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_wb_fields got rd=%0d rdata=%h want 0", wb_rd_o, wb_mem_rdata_o); end
    n_checks++; if (dmem_address !== 32'd0 || dmem_wmask !== 4'd0) begin n_fail++; $display("FAIL reset_dmem got addr=%h mask=%b want 0", dmem_address, dmem_wmask); end
  endtask

  task automatic test_sw_wait;
    drive_op(1'b1, 1'b0, 1'b1, sw, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    n_checks++; if (obs_stall_cycles !== 3) begin n_fail++; $display("FAIL sw_stall_cycles got=%0d want=3", obs_stall_cycles); end
    n_checks++; if (obs_cycles !== 4) begin n_fail++; $display("FAIL sw_latency got=%0d want=4", obs_cycles); end
    n_checks++; if (obs_write0 !== 1'b1 || obs_read0 !== 1'b0) begin n_fail++; $display("FAIL sw_strobes got w=%b r=%b want w=1 r=0", obs_write0, obs_read0); end
    n_checks++; if (obs_wmask0 !== 4'b1111 || obs_wdata0 !== 32'hDEADBEEF || obs_addr0 !== 32'h100) begin n_fail++; $display("FAIL sw_request got mask=%b data=%h addr=%h want 1111 deadbeef 100", obs_wmask0, obs_wdata0, obs_addr0); end
    n_checks++; if (obs_changed !== 1'b0) begin n_fail++; $display("FAIL sw_request_steady got changed=%b want 0", obs_changed); end
    n_checks++; if (obs_bubbles !== 3) begin n_fail++; $display("FAIL sw_bubbles got=%0d want=3", obs_bubbles); end
    n_checks++; if (wb_valid_o !== 1'b1 || wb_rvfi_o.mem_wmask !== 4'b1111) begin n_fail++; $display("FAIL sw_wb got valid=%b wmask=%b want 1 1111", wb_valid_o, wb_rvfi_o.mem_wmask); end
  endtask

  task automatic test_sb;
    drive_op(1'b1, 1'b0, 1'b1, sb, 32'h103, 32'h000000AB, 32'h0, 0);
    n_checks++; if (obs_addr0 !== 32'h100 || obs_wmask0 !== 4'b1000 || obs_wdata0 !== 32'hAB000000) begin n_fail++; $display("FAIL sb_request got addr=%h mask=%b data=%h want 100 1000 ab000000", obs_addr0, obs_wmask0, obs_wdata0); end
    n_checks++; if (obs_stall_cycles !== 0 || obs_cycles !== 1) begin n_fail++; $display("FAIL sb_no_stall got stalls=%0d cycles=%0d want 0 1", obs_stall_cycles, obs_cycles); end
    n_checks++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL sb_wb_valid got=%b want=1", wb_valid_o); end
  endtask

  task automatic test_lh;
    drive_op(1'b1, 1'b1, 1'b0, lh, 32'h202, 32'h0, 32'h80011234, 1);
    n_checks++; if (wb_mem_rdata_o[15:0] !== 16'h8001) begin n_fail++; $display("FAIL lh_rdata got=%h want=8001", wb_mem_rdata_o[15:0]); end
    n_checks++; if (wb_rvfi_o.mem_rmask !== 4'b1100 || wb_rvfi_o.mem_rdata !== 32'h80011234 || wb_rvfi_o.mem_addr !== 32'h202) begin n_fail++; $display("FAIL lh_rvfi got rmask=%b rdata=%h addr=%h want 1100 80011234 202", wb_rvfi_o.mem_rmask, wb_rvfi_o.mem_rdata, wb_rvfi_o.mem_addr); end
    n_checks++; if (obs_read0 !== 1'b1 || obs_addr0 !== 32'h200) begin n_fail++; $display("FAIL lh_request got read=%b addr=%h want 1 200", obs_read0, obs_addr0); end
  endtask

  task automatic test_misaligned;
    drive_op(1'b1, 1'b1, 1'b0, lw, 32'h301, 32'h0, 32'h0, 0);
    n_checks++; if (obs_req_cycles !== 0 || obs_stall_cycles !== 0) begin n_fail++; $display("FAIL mis_no_request got req=%0d stall=%0d want 0 0", obs_req_cycles, obs_stall_cycles); end
    n_checks++; if (wb_misaligned_o !== 1'b1 || wb_rvfi_o.mem_rmask !== 4'd0) begin n_fail++; $display("FAIL mis_wb got mis=%b rmask=%b want 1 0000", wb_misaligned_o, wb_rvfi_o.mem_rmask); end
  endtask

  task automatic test_back_to_back;
    logic exp_seq[5];
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wb_hist.delete();
    drive_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 0);
    drive_op(1'b1, 1'b1, 1'b0, lbu, 32'h0, 32'h0, 32'h11223344, 1);
    drive_op(1'b1, 1'b1, 1'b0, lbu, 32'h1, 32'h0, 32'h55667788, 1);
    n_checks++; if (wb_hist.size() !== 5) begin n_fail++; $display("FAIL b2b_length got=%0d want=5", wb_hist.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_checks++; if (wb_hist[i] !== exp_seq[i]) begin n_fail++; $display("FAIL b2b_seq[%0d] got=%b want=%b", i, wb_hist[i], exp_seq[i]); end
    end
    n_checks++; if (wb_mem_rdata_o[7:0] !== 8'h77) begin n_fail++; $display("FAIL b2b_lbu_rdata got=%h want=77", wb_mem_rdata_o[7:0]); end
  endtask

  task automatic test_reset_mid_wait;
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_is_store_i = 1'b0;
    ex_funct3_i = lw; ex_alu_out_i = 32'h40; dmem_resp = 1'b0;
    @(negedge clk);
    n_checks++; if (dmem_read !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL rstw_pending got read=%b stall=%b want 1 1", dmem_read, stall_o); end
    @(posedge clk); #1;
    n_checks++; if (dmem_read !== 1'b1) begin n_fail++; $display("FAIL rstw_waiting got read=%b want 1", dmem_read); end
    #2 rst_n = 1'b0; #1;
    n_checks++; if (dmem_read !== 1'b0 || stall_o !== 1'b0 || wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstw_async got read=%b stall=%b valid=%b want 000", dmem_read, stall_o, wb_valid_o); end
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (wb_valid_o !== 1'b0 || stall_o !== 1'b0 || dut.state_q !== IDLE) begin n_fail++; $display("FAIL rstw_after got valid=%b stall=%b state=%0d want 0 0 IDLE", wb_valid_o, stall_o, dut.state_q); end
  endtask

  task automatic test_random;
    logic [2:0]  ld_f3[5];
    logic        v, ld, st, mis, memop;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata, e_wdata, e_rdata;
    logic [3:0]  e_mask;
    int          nb, off, nwait;
    rvfi_sigs    e_rvfi;
    ld_f3 = '{lb, lh, lw, lbu, lhu};
    for (int it = 0; it < 60; it++) begin
      v = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 2))
        0:       begin ld = 1'b0; st = 1'b0; f3 = 3'($urandom); end
        1:       begin ld = 1'b1; st = 1'b0; f3 = ld_f3[$urandom_range(0, 4)]; end
        default: begin ld = 1'b0; st = 1'b1; f3 = 3'($urandom_range(0, 2)); end
      endcase
      addr = $urandom; rs2 = $urandom; rdata = $urandom;
      nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off   = addr % 4;
      mis   = (ld || st) && ((addr % nb) != 0);
      memop = v && (ld || st) && !mis;
      nwait = memop ? $urandom_range(0, 3) : 0;
      e_mask  = memop ? 4'(((1 << nb) - 1) << off) : 4'd0;
      e_wdata = 32'((64'(rs2) * (64'd1 << (8 * off))) % 64'h1_0000_0000);
      e_rdata = rdata / (32'd1 << (8 * off));
      drive_op(v, ld, st, f3, addr, rs2, rdata, nwait);
      e_rvfi           = ex_rvfi_i;
      e_rvfi.mem_addr  = addr;
      e_rvfi.mem_rmask = (memop && ld) ? e_mask : 4'd0;
      e_rvfi.mem_wmask = (memop && st) ? e_mask : 4'd0;
      e_rvfi.mem_rdata = (memop && ld) ? rdata : 32'd0;
      e_rvfi.mem_wdata = (memop && st) ? e_wdata : 32'd0;
      n_checks++; if (obs_cycles !== nwait + 1 || obs_stall_cycles !== nwait) begin n_fail++; $display("FAIL rnd%0d_timing got cycles=%0d stalls=%0d want %0d %0d", it, obs_cycles, obs_stall_cycles, nwait + 1, nwait); end
      n_checks++; if (obs_read0 !== (memop && ld) || obs_write0 !== (memop && st)) begin n_fail++; $display("FAIL rnd%0d_strobes got r=%b w=%b want r=%b w=%b", it, obs_read0, obs_write0, memop && ld, memop && st); end
      if (memop) begin
        n_checks++; if (obs_addr0 !== (addr & ~32'd3) || obs_changed !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_addr got=%h changed=%b want=%h", it, obs_addr0, obs_changed, addr & ~32'd3); end
      end
      if (memop && st) begin
        n_checks++; if (obs_wmask0 !== e_mask || obs_wdata0 !== e_wdata) begin n_fail++; $display("FAIL rnd%0d_store got mask=%b data=%h want %b %h", it, obs_wmask0, obs_wdata0, e_mask, e_wdata); end
      end
      if (mis) begin
        n_checks++; if (obs_wmask0 !== 4'd0 || obs_req_cycles !== 0) begin n_fail++; $display("FAIL rnd%0d_mis_quiet got mask=%b req=%0d want 0 0", it, obs_wmask0, obs_req_cycles); end
      end
      if (memop && ld) begin
        n_checks++; if (wb_mem_rdata_o !== e_rdata) begin n_fail++; $display("FAIL rnd%0d_load_data got=%h want=%h", it, wb_mem_rdata_o, e_rdata); end
      end
      n_checks++; if (wb_valid_o !== v || wb_rd_o !== ex_rd_i || wb_alu_out_o !== addr) begin n_fail++; $display("FAIL rnd%0d_wb got valid=%b rd=%0d alu=%h want %b %0d %h", it, wb_valid_o, wb_rd_o, wb_alu_out_o, v, ex_rd_i, addr); end
      n_checks++; if (wb_imm_o !== ex_imm_i || wb_pc_plus4_o !== ex_pc_plus4_i || wb_br_en_o !== ex_br_en_i || wb_regfilemux_sel_o !== ex_regfilemux_sel_i) begin n_fail++; $display("FAIL rnd%0d_passthru got imm=%h pc4=%h br=%b sel=%0d want %h %h %b %0d", it, wb_imm_o, wb_pc_plus4_o, wb_br_en_o, wb_regfilemux_sel_o, ex_imm_i, ex_pc_plus4_i, ex_br_en_i, ex_regfilemux_sel_i); end
      if (v) begin
        n_checks++; if (wb_misaligned_o !== mis) begin n_fail++; $display("FAIL rnd%0d_misaligned got=%b want=%b", it, wb_misaligned_o, mis); end
        n_checks++; if (wb_rvfi_o !== e_rvfi) begin n_fail++; $display("FAIL rnd%0d_rvfi got masks r=%b w=%b addr=%h want r=%b w=%b addr=%h", it, wb_rvfi_o.mem_rmask, wb_rvfi_o.mem_wmask, wb_rvfi_o.mem_addr, e_rvfi.mem_rmask, e_rvfi.mem_wmask, e_rvfi.mem_addr); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid_i = 1'b0; ex_is_load_i = 1'b0; ex_is_store_i = 1'b0; ex_br_en_i = 1'b0;
    ex_alu_out_i = '0; ex_rs2_i = '0; ex_imm_i = '0; ex_pc_plus4_i = '0;
    ex_funct3_i = '0; ex_regfilemux_sel_i = rf_alu_out; ex_rd_i = '0; ex_rvfi_i = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_sw_wait();
    test_sb();
    test_lh();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage, sitting between the EX/MEM pipeline register and the writeback stage. It issues data-memory reads and writes and generates byte masks and shifted store data for stores. It holds the pipeline until the memory responds and registers the MEM/WB bundle. The WB stage then selects and sign/zero-extends lane-aligned load data, so loaded bytes and halfwords must arrive at bits [7:0] and [15:0].

## Interface
Parameters:
- none. Widths are fixed by `rv32i_types`.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `ex_valid_i`  in  1  EX/MEM slot holds a live instruction
- `ex_alu_out_i`  in  32  ALU result; the effective address for loads and stores
- `ex_rs2_i`  in  32  store source data
- `ex_funct3_i`  in  3  load/store width (`rv32i_types` load/store funct3 encodings)
- `ex_is_load_i`, `ex_is_store_i`  in  1 each  memory-op kind; never both high
- `ex_br_en_i`  in  1  pass-through
- `ex_imm_i`  in  32  pass-through
- `ex_pc_plus4_i`  in  32  pass-through
- `ex_regfilemux_sel_i`  in  `regfilemux_sel_t`  pass-through
- `ex_rd_i`  in  5  pass-through
- `ex_rvfi_i`  in  `rvfi_sigs`  pass-through
- `dmem_address`  out  32  word-aligned address, {addr[31:2], 2'b00}
- `dmem_read`, `dmem_write`  out  1 each  request strobes
- `dmem_wmask`  out  4  byte enables
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_rdata`  in  32  read data
- `dmem_resp`  in  1  access complete
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `wb_valid_o`  out  1  registered
- `wb_mem_rdata_o`  out  32  registered; load data shifted right by 8×addr[1:0]
- `wb_alu_out_o`  out  32  registered
- `wb_br_en_o`  out  1  registered
- `wb_imm_o`  out  32  registered
- `wb_pc_plus4_o`  out  32  registered
- `wb_regfilemux_sel_o`  out  `regfilemux_sel_t`  registered
- `wb_rd_o`  out  5  registered
- `wb_misaligned_o`  out  1  registered
- `wb_rvfi_o`  out  `rvfi_sigs`  registered

## Operation
- **memop definition:** memop = ex_valid_i & (is_load | is_store) & ~misaligned.
- **Misalignment rule:** word accesses require addr[1:0]==0; halfword accesses require addr[0]==0.
- **Misaligned access:** issues no request. It passes to WB in one cycle with `wb_misaligned_o`=1 and masks 0.
- **FSM states:** IDLE and WAIT.
- **IDLE with memop:** `dmem_read` or `dmem_write` is asserted combinationally in the same cycle.
  - If `dmem_resp`=1 in that cycle, the access completes: zero-wait.
  - Otherwise the next state is WAIT.
- **WAIT:** request outputs stay asserted with identical address, mask and data until `dmem_resp`=1. Then next state is IDLE.
- **Stall:** `stall_o` = memop & ~`dmem_resp`, combinational. Upstream inputs are stable while `stall_o`=1.
- **MEM/WB register loads when `stall_o`=0:**
  - It captures the pass-throughs plus aligned `dmem_rdata`.
  - If `stall_o`=1, it loads a bubble: `wb_valid_o`=0 and `wb_rd_o`=0; other fields don't-care.
- **Store masks** (off = addr[1:0]):
  - sb: 4'b0001<<off, data = rs2<<(8·off).
  - sh: 4'b0011<<off, data = rs2<<(8·off).
  - sw: 4'b1111, data = rs2.
- **Load mask:** the load rmask follows the same pattern as the store mask. It feeds rvfi only; `dmem_read` always fetches the full word.
- **rvfi capture:** the stage overwrites mem_addr (unaligned), mem_rmask, mem_wmask, mem_rdata (raw word) and mem_wdata in the captured rvfi. rd_wdata is left for WB.
- **Non-memory instruction:** `ex_valid_i`=1 with no load/store passes through in one cycle with no dmem activity.

## Timing
- **Reset:** all outputs 0 and state IDLE, including `stall_o`, `dmem_read`, `dmem_write` and `wb_valid_o`.
- **Reset mid-WAIT:** requests drop asynchronously and no MEM/WB update occurs.
- **Latency:** EX/MEM → WB outputs take 1 cycle for non-memory ops, misaligned ops and zero-wait memory. With N wait cycles they take 1+N cycles.
- **Back-to-back memory ops:** a new memop may be issued in the cycle after a resp, from IDLE.
- **Spurious response:** `dmem_resp` while neither strobe is asserted is ignored.
- **Response timing:** `dmem_resp` is sampled only on rising edges. `dmem_rdata` is valid only while `dmem_resp`=1.

## Structure
- **Package additions to `rv32i_types`:**
  - `mem_state_t` {IDLE, WAIT}.
  - Reuse the existing load/store funct3 enums; add them if absent.
- **Sub-module `mem_align`:** combinational. Takes addr[1:0], funct3, rs2 and rdata. Produces wmask, rmask, wdata, aligned rdata and misaligned.
- **Top level:** holds the FSM and the MEM/WB register.

## Test plan
- sw 0xDEADBEEF at 0x100, resp after 3 cycles → `stall_o`=1 for 3 cycles; wmask 4'b1111; then `wb_valid_o`=1 and `stall_o`=0.
- sb 0x000000AB at 0x103, zero-wait → `dmem_address`=0x100, wmask 4'b1000, wdata 0xAB000000, no stall.
- lh at 0x202, rdata 0x8001_1234 → `wb_mem_rdata_o`[15:0]=0x8001; rvfi mem_rmask 4'b1100.
- lw at 0x301 → no strobe, `wb_misaligned_o`=1 next cycle, `stall_o`=0.
- ALU op, then lbu at 0x0, then lbu at 0x1, with resp 1 cycle late each → WB sees valid, bubble, valid, bubble, valid in order.
- `rst_n` low during WAIT → `dmem_read` drops immediately; after release, state IDLE and `wb_valid_o`=0.
